// File: rtl/md5_match_controller_if.sv
// md5_match_controller_if: host command/response link (valid/ready command in, one-cycle response strobe out)
interface md5_match_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  modport master (output cmd_valid, cmd_data, input cmd_ready, rsp_valid, rsp_data);
  modport slave (input cmd_valid, cmd_data, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/md5_match_controller.sv
// md5_match_controller: delays candidates by the MD5 latency, compares digests to targets, latches the first hit; PARTIAL_MATCH_EN adds a masked dig_a compare
module md5_match_controller #(
  parameter int PIPE_DEPTH  = 64,
  parameter int NUM_TARGETS = 4,
  parameter int TEXT_W      = 128,
  parameter int COUNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  md5_match_controller_if.slave cmd,
  output logic                 gen_reset,
  output logic                 gen_enable,
  output logic [7:0]           range_min,
  output logic [7:0]           range_max,
  input  logic                 cand_valid,
  input  logic [TEXT_W-1:0]    cand_text,
  input  logic [31:0]          dig_a,
  input  logic [31:0]          dig_b,
  input  logic [31:0]          dig_c,
  input  logic [31:0]          dig_d,
  output logic                 matched,
  output logic [3:0]           match_idx,
  output logic [TEXT_W-1:0]    match_text
);
  typedef enum logic {IDLE, ARG} state_t;
  typedef enum logic [1:0] {A_TGT, A_RANGE, A_MODE, A_MASK} arg_t;
  localparam int PW = $clog2(PIPE_DEPTH);
  localparam int NW = TEXT_W / 32;
  state_t state_q, state_d;
  arg_t arg_q, arg_d;
  logic [9:0] sel_q, sel_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic gen_reset_q, gen_reset_d, gen_en_q, gen_en_d, stop_q, stop_d, matched_q, matched_d;
  logic [7:0] rmin_q, rmin_d, rmax_q, rmax_d;
  logic [NUM_TARGETS-1:0][3:0][31:0] tgt_q, tgt_d;
  logic [NUM_TARGETS-1:0] en_q, en_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0] hits_q, hits_d;
  logic [3:0] idx_q, idx_d, cmp_idx_q, cmp_idx_d;
  logic [TEXT_W-1:0] mtext_q, mtext_d, cmp_text_q, cmp_text_d;
  logic cmp_hit_q, cmp_hit_d, cmp_vld_q, cmp_vld_d;
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [TEXT_W-1:0] ram [PIPE_DEPTH];
  logic [31:0] w;
`ifdef PARTIAL_MATCH_EN
  logic [31:0] mask_q, mask_d;
`endif
  assign w = cmd.cmd_data;
  assign cmd.cmd_ready = state_q inside {IDLE, ARG};
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data = rsp_data_q;
  assign gen_reset = gen_reset_q;
  assign gen_enable = gen_en_q;
  assign range_min = rmin_q;
  assign range_max = rmax_q;
  assign matched = matched_q;
  assign match_idx = idx_q;
  assign match_text = mtext_q;
  always_comb begin
    state_d = state_q;
    arg_d = arg_q;
    sel_d = sel_q;
    gen_reset_d = gen_reset_q;
    gen_en_d = gen_en_q;
    stop_d = stop_q;
    matched_d = matched_q;
    rmin_d = rmin_q;
    rmax_d = rmax_q;
    tgt_d = tgt_q;
    en_d = en_q;
    hits_d = hits_q;
    idx_d = idx_q;
    mtext_d = mtext_q;
`ifdef PARTIAL_MATCH_EN
    mask_d = mask_q;
`endif
    ptr_d = ptr_q == PW'(PIPE_DEPTH - 1) ? '0 : ptr_q + 1'b1;
    vld_d = {vld_q[PIPE_DEPTH-2:0], cand_valid && gen_en_q};
    cmp_vld_d = vld_q[PIPE_DEPTH-1];
    cmp_text_d = ram[ptr_q];
    cmp_hit_d = 1'b0;
    cmp_idx_d = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
`ifdef PARTIAL_MATCH_EN
      if (vld_q[PIPE_DEPTH-1] && en_q[i] && (dig_a & mask_q) == (tgt_q[i][0] & mask_q)) begin
`else
      if (vld_q[PIPE_DEPTH-1] && en_q[i] && {dig_d, dig_c, dig_b, dig_a} == tgt_q[i]) begin
`endif
        cmp_hit_d = 1'b1;
        cmp_idx_d = 4'(i);
      end
    count_d = count_q + COUNT_W'(cmp_vld_q && gen_en_q);
    if (cmp_hit_q && gen_en_q && !(matched_q && stop_q)) begin
      hits_d = &hits_q ? hits_q : hits_q + 32'd1;
      if (!matched_q) begin
        matched_d = 1'b1;
        idx_d = cmp_idx_q;
        mtext_d = cmp_text_q;
        gen_en_d = !stop_q;
      end
    end
    rsp_valid_d = cmd.cmd_valid && cmd.cmd_ready;
    rsp_data_d = '0;
    if (rsp_valid_d && state_q == ARG) begin
      state_d = IDLE;
      rsp_data_d = arg_q == A_TGT ? 32'h00FF00FF : arg_q == A_RANGE ? 32'hAAAAAAAA :
                   arg_q == A_MODE ? 32'h0000FFFF : 32'h0;
      if (arg_q == A_TGT)
        for (int i = 0; i < NUM_TARGETS; i++)
          if (sel_q[9:2] == 8'(i)) begin
            tgt_d[i][sel_q[1:0]] = w;
            en_d[i] = &sel_q[1:0];
          end
      if (arg_q == A_RANGE) begin
        rmin_d = w[7:0];
        rmax_d = w[15:8];
      end
      if (arg_q == A_MODE) stop_d = w[0];
`ifdef PARTIAL_MATCH_EN
      if (arg_q == A_MASK) mask_d = w;
`endif
    end else if (rsp_valid_d) begin
      rsp_data_d = 32'hDEADC0DE;
      if (w == 32'h0) rsp_data_d = '0;
      else if (w == 32'h52300000) begin
        gen_reset_d = 1'b1;
        gen_en_d = 1'b0;
        rsp_data_d = '0;
      end else if (w == 32'h52300001) begin
        gen_reset_d = 1'b0;
        gen_en_d = 1'b1;
        count_d = '0;
        hits_d = '0;
        matched_d = 1'b0;
        idx_d = idx_q;
        mtext_d = mtext_q;
        vld_d = '0;
        cmp_vld_d = 1'b0;
        cmp_hit_d = 1'b0;
        rsp_data_d = 32'h55555555;
      end else if (w[31:16] == 16'h5231 && w[7:2] == 6'h0) begin
        state_d = ARG;
        arg_d = A_TGT;
        sel_d = {w[15:8], w[1:0]};
        rsp_data_d = 32'h00FF00FF;
      end else if (w == 32'h52302000) begin
        state_d = ARG;
        arg_d = A_RANGE;
        rsp_data_d = 32'hAAAAAAAA;
      end else if (w == 32'h52305000) begin
        state_d = ARG;
        arg_d = A_MODE;
        rsp_data_d = 32'h0000FFFF;
`ifdef PARTIAL_MATCH_EN
      end else if (w == 32'h52307000) begin
        state_d = ARG;
        arg_d = A_MASK;
        rsp_data_d = '0;
`endif
      end else if (w == 32'h52306000) begin
        en_d = '0;
        rsp_data_d = '0;
      end else if (w == 32'h52303000) rsp_data_d = count_q[31:0];
      else if (w == 32'h52303001) rsp_data_d = 32'(count_q >> 32);
      else if (w == 32'h52303002) rsp_data_d = hits_q;
      else if (w == 32'h52304000) rsp_data_d = {24'b0, idx_q, 1'b0, gen_en_q, matched_q, |en_q};
      else if (w[31:4] == 28'h4400000) begin
        rsp_data_d = '0;
        for (int k = 0; k < NW; k++)
          if ({28'b0, w[3:0]} == 32'(k)) rsp_data_d = mtext_q[32*k +: 32];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      arg_q <= A_TGT;
      sel_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      gen_reset_q <= 1'b1;
      gen_en_q <= 1'b0;
      stop_q <= 1'b1;
      matched_q <= 1'b0;
      rmin_q <= 8'h61;
      rmax_q <= 8'h7a;
      tgt_q <= '0;
      en_q <= '0;
      count_q <= '0;
      hits_q <= '0;
      idx_q <= '0;
      mtext_q <= '0;
      cmp_hit_q <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      cmp_text_q <= '0;
      vld_q <= '0;
      ptr_q <= '0;
`ifdef PARTIAL_MATCH_EN
      mask_q <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q <= state_d;
      arg_q <= arg_d;
      sel_q <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      gen_reset_q <= gen_reset_d;
      gen_en_q <= gen_en_d;
      stop_q <= stop_d;
      matched_q <= matched_d;
      rmin_q <= rmin_d;
      rmax_q <= rmax_d;
      tgt_q <= tgt_d;
      en_q <= en_d;
      count_q <= count_d;
      hits_q <= hits_d;
      idx_q <= idx_d;
      mtext_q <= mtext_d;
      cmp_hit_q <= cmp_hit_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      cmp_text_q <= cmp_text_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
`ifdef PARTIAL_MATCH_EN
      mask_q <= mask_d;
`endif
    end
  end
  always_ff @(posedge clk) ram[ptr_q] <= cand_text;
endmodule

// File: tb/tb_md5_match_controller.sv
// tb_md5_match_controller: scoreboard bench with a behavioural MD5 core delay model and directed command vectors
module tb_md5_match_controller;
  localparam int PD = 64;
  localparam logic [31:0] P1 = 32'h63616e64, P2 = 32'h74657374, P3 = 32'h64756f73, P4 = 32'h6a756e6b, P5 = 32'h66726573;
  localparam logic [31:0] START = 32'h52300001, STOP = 32'h52300000, STATUS = 32'h52304000;
  localparam logic [31:0] CNT_LO = 32'h52303000, CNT_HI = 32'h52303001, HITS = 32'h52303002;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic cand_valid = 1'b0;
  logic [127:0] cand_text = '0;
  logic [31:0] dig_a, dig_b, dig_c, dig_d;
  logic gen_reset, gen_enable, matched;
  logic [7:0] range_min, range_max;
  logic [3:0] match_idx;
  logic [127:0] match_text;
  md5_match_controller_if ifc();
  md5_match_controller #(.PIPE_DEPTH(PD), .NUM_TARGETS(4), .TEXT_W(128), .COUNT_W(64)) dut (
    .clk(clk), .reset(reset), .cmd(ifc),
    .gen_reset(gen_reset), .gen_enable(gen_enable),
    .range_min(range_min), .range_max(range_max),
    .cand_valid(cand_valid), .cand_text(cand_text),
    .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d),
    .matched(matched), .match_idx(match_idx), .match_text(match_text)
  );
  logic [127:0] pipe [PD];
  logic [127:0] hot_text [4];
  logic [127:0] hot_dig [4];
  int hot_n = 0;
  logic [31:0] exp_q [$];
  string tag_q [$];
  int passed = 0, total = 0, stuck = 0;
  function automatic logic [127:0] txt(input logic [31:0] pre, input int i);
    txt = {pre, 32'h0, 32'h0, 32'(i)};
  endfunction
  function automatic logic [127:0] digest_of(input logic [127:0] t);
    digest_of = {t[31:0] ^ 32'h5a5a0000, ~t[31:0], 32'h12345678, t[127:96]};
    for (int i = 0; i < hot_n; i++)
      if (t == hot_text[i]) digest_of = hot_dig[i];
  endfunction
  always @(posedge clk) begin
    pipe[0] <= digest_of(cand_text);
    for (int i = 1; i < PD; i++) pipe[i] <= pipe[i-1];
  end
  assign {dig_a, dig_b, dig_c, dig_d} = pipe[PD-1];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk)
    if (ifc.rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got %h expected no response", ifc.rsp_data);
      end else chk(tag_q.pop_front(), {96'b0, ifc.rsp_data}, {96'b0, exp_q.pop_front()});
    end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [31:0] w, input logic [31:0] e, input string tag);
    int n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data = w;
    while (!ifc.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      total++;
      $display("FAIL %s_ready: got cmd_ready 0 expected 1", tag);
    end else begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    tick();
    ifc.cmd_valid = 1'b0;
  endtask
  task automatic prog(input int t, input logic [127:0] d);
    for (int k = 0; k < 4; k++) begin
      send(32'h52310000 | (32'(t) << 8) | 32'(k), 32'h00FF00FF, "tgt_op");
      send(d[127-32*k -: 32], 32'h00FF00FF, "tgt_arg");
    end
  endtask
  task automatic feed(input logic [31:0] pre, input int n);
    for (int i = 0; i < n; i++) begin
      cand_valid = 1'b1;
      cand_text = txt(pre, i);
      tick();
    end
    cand_valid = 1'b0;
  endtask
  initial begin
    logic [127:0] d0, d1, d2;
    d2 = {32'h2971bc83, 32'h9b41f6a4, 32'h955620c0, 32'h9067fbfd};
    d0 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    d1 = {32'haaaa0001, 32'hbbbb0002, 32'hcccc0003, 32'hdddd0004};
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data = '0;
    tick(3);
    reset = 1'b0;
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_cmd_ready", ifc.cmd_ready, 1);
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_gen_enable", gen_enable, 0);
    chk("rst_range_min", range_min, 8'h61);
    chk("rst_range_max", range_max, 8'h7a);
    chk("rst_matched", matched, 0);
    send(STATUS, 32'h0, "status_reset");
    prog(2, d2);
    send(STATUS, 32'h1, "status_enabled");
    hot_text[0] = txt(P1, 37);
    hot_dig[0] = d2;
    hot_n = 1;
    send(START, 32'h55555555, "start1");
    feed(P1, 100);
    tick(PD + 5);
    chk("t2_matched", matched, 1);
    chk("t2_match_idx", match_idx, 2);
    chk("t2_match_text", match_text, txt(P1, 37));
    chk("t2_gen_enable", gen_enable, 0);
    chk("t2_gen_reset", gen_reset, 0);
    send(CNT_LO, 32'd38, "t2_count_lo");
    send(CNT_HI, 32'd0, "t2_count_hi");
    send(HITS, 32'd1, "t2_hits");
    send(32'h44000000, 32'd37, "t2_mtext0");
    send(32'h44000003, P1, "t2_mtext3");
    send(32'h44000004, 32'd0, "t2_mtext_oob");
    send(STATUS, 32'h23, "t2_status");
    send(32'h52305000, 32'h0000FFFF, "mode_op");
    send(32'h0, 32'h0000FFFF, "mode_arg");
    prog(0, d0);
    hot_text[0] = txt(P2, 5);
    hot_dig[0] = d0;
    hot_text[1] = txt(P2, 9);
    hot_dig[1] = d0;
    hot_n = 2;
    send(START, 32'h55555555, "start2");
    feed(P2, 20);
    tick(PD + 5);
    chk("t3_matched", matched, 1);
    chk("t3_match_idx", match_idx, 0);
    chk("t3_match_text", match_text, txt(P2, 5));
    chk("t3_gen_enable", gen_enable, 1);
    send(HITS, 32'd2, "t3_hits");
    send(CNT_LO, 32'd20, "t3_count_lo");
    prog(1, d1);
    prog(3, d1);
    hot_text[0] = txt(P3, 3);
    hot_dig[0] = d1;
    hot_n = 1;
    send(START, 32'h55555555, "start3");
    feed(P3, 10);
    tick(PD + 5);
    chk("t4_matched", matched, 1);
    chk("t4_match_idx", match_idx, 1);
    send(HITS, 32'd1, "t4_hits");
    send(STATUS, 32'h17, "t4_status");
    send(STOP, 32'h0, "stop");
    chk("stop_gen_reset", gen_reset, 1);
    chk("stop_gen_enable", gen_enable, 0);
    chk("stop_matched_held", matched, 1);
    hot_text[0] = txt(P4, 0);
    cand_text = txt(P4, 0);
    cand_valid = 1'b1;
    tick(PD + 2);
    cand_valid = 1'b0;
    send(START, 32'h55555555, "start4");
    send(CNT_LO, 32'd0, "t5_count_at_start");
    for (int i = 0; i < PD + 20; i++) begin
      cand_valid = i < 10;
      if (i < 10) cand_text = txt(P5, i);
      tick();
      if (matched) stuck++;
    end
    cand_valid = 1'b0;
    chk("t5_no_hit_cycles", stuck, 0);
    send(CNT_LO, 32'd10, "t5_count_lo");
    send(HITS, 32'd0, "t5_hits");
    send(32'h52302000, 32'hAAAAAAAA, "t6_range_op");
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("t6_rsp_valid", ifc.rsp_valid, 0);
    chk("t6_gen_reset", gen_reset, 1);
    chk("t6_matched", matched, 0);
    chk("t6_match_text", match_text, 0);
    send(32'h00007A41, 32'hDEADC0DE, "t6_word_after_reset");
    chk("t6_range_min", range_min, 8'h61);
    chk("t6_range_max", range_max, 8'h7a);
    send(32'h52307000, 32'hDEADC0DE, "mask_op_absent");
    send(STATUS, 32'h0, "t6_status");
    tick(3);
    chk("rsp_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
